// File: rtl/hamm_pkg.sv
// Shared Hamming(8,4) SECDED definitions: serial transmitter states, codeword
// bit positions and the encoder used by both the transmit and receive sides.
package hamm_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    // Codeword bit positions: c[i] is Hamming position i, c[0] is overall parity.
    localparam int unsigned P0 = 0;
    localparam int unsigned P1 = 1;
    localparam int unsigned P2 = 2;
    localparam int unsigned D0 = 3;
    localparam int unsigned P4 = 4;
    localparam int unsigned D1 = 5;
    localparam int unsigned D2 = 6;
    localparam int unsigned D3 = 7;

    function automatic logic [7:0] hamm_encode(input logic [3:0] d);
        logic [7:0] c;
        c     = '0;
        c[D0] = d[0];
        c[D1] = d[1];
        c[D2] = d[2];
        c[D3] = d[3];
        c[P1] = c[D0] ^ c[D1] ^ c[D3];
        c[P2] = c[D0] ^ c[D2] ^ c[D3];
        c[P4] = c[D1] ^ c[D2] ^ c[D3];
        c[P0] = ^c[7:1];
        return c;
    endfunction

endpackage

// File: rtl/hamm_bit_timer.sv
// Bit-period counter: counts 0..BIT_CYCLES-1 while enabled and flags the last
// cycle of each bit. Held at zero while disabled so every frame starts aligned.
module hamm_bit_timer #(
    parameter int unsigned BIT_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_en,
    output logic o_tick
);

    logic [7:0] r_cnt;
    logic       w_last;

    assign w_last = (r_cnt == 8'(BIT_CYCLES - 1));
    assign o_tick = i_en && w_last;

    always_ff @(posedge clk) begin
        if (rst || !i_en || w_last) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 8'd1;
        end
    end

endmodule

// File: rtl/hamm_tx_serial.sv
// Hamming(8,4) SECDED transmitter: encodes a nibble and sends start, 8 code bits
// LSB first, stop. Define HAMM_TX_ERRINJ_EN to add the err_mask corruption port.
module hamm_tx_serial
    import hamm_pkg::*;
#(
    parameter int unsigned BIT_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] data_in,
    input  logic       valid_in,
`ifdef HAMM_TX_ERRINJ_EN
    input  logic [7:0] err_mask,
`endif
    output logic       ready_out,
    output logic       tx_out,
    output logic       busy,
    output logic [7:0] code_out,
    output logic       done
);

    tx_state_t  r_state;
    tx_state_t  w_state_nxt;
    logic [2:0] r_idx;
    logic [7:0] r_code;
    logic       r_done;
    logic       w_tick;
    logic       w_accept;
    logic       w_frame_end;
    logic [7:0] w_code_new;

`ifdef HAMM_TX_ERRINJ_EN
    assign w_code_new = hamm_encode(data_in) ^ err_mask;
`else
    assign w_code_new = hamm_encode(data_in);
`endif

    hamm_bit_timer #(
        .BIT_CYCLES(BIT_CYCLES)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .i_en   (r_state != IDLE),
        .o_tick (w_tick)
    );

    always_comb begin
        w_state_nxt = r_state;
        ready_out   = 1'b0;
        tx_out      = 1'b1;
        w_frame_end = 1'b0;
        case (r_state)
            IDLE: begin
                // Reset overrides a simultaneous valid_in, so ready is masked too.
                ready_out = !rst;
                if (valid_in && !rst) begin
                    w_state_nxt = START;
                end
            end
            START: begin
                tx_out = 1'b0;
                if (w_tick) begin
                    w_state_nxt = DATA;
                end
            end
            DATA: begin
                tx_out = r_code[r_idx];
                if (w_tick && (r_idx == 3'd7)) begin
                    w_state_nxt = STOP;
                end
            end
            STOP: begin
                if (w_tick) begin
                    w_state_nxt = IDLE;
                    w_frame_end = 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
        w_accept = ready_out && valid_in;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_idx   <= '0;
            r_code  <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_done  <= w_frame_end;
            if (w_accept) begin
                r_code <= w_code_new;
            end
            // Index wraps 7 -> 0 on its own, leaving it cleared for the next frame.
            if (r_state == DATA && w_tick) begin
                r_idx <= r_idx + 3'd1;
            end else if (r_state != DATA) begin
                r_idx <= '0;
            end
        end
    end

    assign busy     = (r_state != IDLE);
    assign code_out = r_code;
    assign done     = r_done;

endmodule
